// File: rtl/pq_pkg.sv
// Shared definitions for the streaming sorter: controller states and the
// fixed response latency of the attached priority queue.
package pq_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int PQ_RD_LAT = 1;

endpackage

// File: rtl/pq_out_fifo.sv
// Two-entry valid/ready FIFO holding popped queue words (with their last flag)
// until the downstream consumer accepts them.
module pq_out_fifo #(
    parameter int DATA_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_LENGTH-1:0] wr_data,
    input  logic                   wr_last,
    output logic                   valid,
    input  logic                   ready,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   last,
    output logic [1:0]             count
);

    logic [DATA_LENGTH-1:0] mem_data [2];
    logic [1:0]             mem_last;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic                   enq;
    logic                   deq;

    assign valid = (count != 2'd0);
    assign deq   = valid && ready;
    // The issuer budgets pops so a write never lands on a full FIFO; the guard
    // only keeps a misbehaving queue from corrupting the held head word.
    assign enq   = wr_en && ((count != 2'd2) || deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (enq) begin
                mem_data[wr_ptr] <= wr_data;
                mem_last[wr_ptr] <= wr_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    assign data = valid ? mem_data[rd_ptr] : '0;
    assign last = valid && mem_last[rd_ptr];

endmodule

// File: rtl/pq_stream_sorter.sv
// Batch sorter: pushes an upstream batch into an external priority queue, then
// pops it back out in ascending order through a small output FIFO.
module pq_stream_sorter
    import pq_pkg::*;
#(
    parameter int QUEUE_DEPTH = 32,
    parameter int DATA_LENGTH = 32
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_LENGTH-1:0] s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_LENGTH-1:0] m_data,
    output logic                   m_last,
    output logic                   pq_valid,
    output logic                   pq_write,
    output logic [DATA_LENGTH-1:0] pq_data,
    input  logic                   pq_rvalid,
    input  logic [DATA_LENGTH-1:0] pq_rdata,
    input  logic                   pq_empty,
    output logic                   err
);

    localparam int CW         = $clog2(QUEUE_DEPTH) + 1;
    localparam int OUT_BUDGET = PQ_RD_LAT + 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] pop_cnt;
    logic          outstanding;
    logic          pend_last;
    logic          push_d1;
    logic          push_d2;
    logic          accept;
    logic          fill_done;
    logic          drain_done;
    logic          pop_issue;
    logic          last_pop;
    logic          m_fire;
    logic [1:0]    fifo_count;
    logic [2:0]    load;
    logic          err_set;

    assign s_ready    = (state == FILL) && (cnt < CW'(QUEUE_DEPTH));
    assign accept     = s_valid && s_ready;
    assign fill_done  = accept && (s_last || (cnt + CW'(1) == CW'(QUEUE_DEPTH)));
    assign m_fire     = m_valid && m_ready;
    assign drain_done = m_fire && m_last;

    // Words already committed to the FIFO (net of this cycle's hand-off) plus
    // the response in flight; counting the hand-off keeps 1 word/cycle.
    assign load      = 3'(fifo_count) + 3'(outstanding) - 3'(m_fire);
    assign pop_issue = (state == DRAIN) && (pop_cnt < cnt) && (load < 3'(OUT_BUDGET));
    assign last_pop  = pop_issue && (pop_cnt == cnt - CW'(1));

    assign pq_valid = accept || pop_issue;
    assign pq_write = accept;
    assign pq_data  = accept ? s_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fill_done)  state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= FILL;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt         <= '0;
            pop_cnt     <= '0;
            outstanding <= 1'b0;
            pend_last   <= 1'b0;
        end else begin
            if (drain_done) begin
                cnt     <= '0;
                pop_cnt <= '0;
            end else begin
                if (accept)    cnt     <= cnt + CW'(1);
                if (pop_issue) pop_cnt <= pop_cnt + CW'(1);
            end
            outstanding <= pop_issue;
            pend_last   <= last_pop;
        end
    end

    // The queue's empty flag trails requests by two cycles, so it is only
    // trusted once no push has happened in the preceding two cycles.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            push_d1 <= 1'b0;
            push_d2 <= 1'b0;
        end else begin
            push_d1 <= accept;
            push_d2 <= push_d1;
        end
    end

    assign err_set = (pq_rvalid && !outstanding)
                   || (outstanding && !pq_rvalid)
                   || (pop_issue && pq_empty && !push_d1 && !push_d2);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)        err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    pq_out_fifo #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_out_fifo (
        .clk    (CLK),
        .rst_n  (RSTn),
        .wr_en  (pq_rvalid && outstanding),
        .wr_data(pq_rdata),
        .wr_last(pend_last),
        .valid  (m_valid),
        .ready  (m_ready),
        .data   (m_data),
        .last   (m_last),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_pq_stream_sorter.sv
// Self-checking bench: behavioural priority queue (1-cycle pop latency, empty
// flag two cycles behind) plus a sorted-expectation scoreboard.
module tb_pq_stream_sorter;

    localparam int QD = 4;
    localparam int DL = 8;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DL-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DL-1:0] m_data;
    logic          m_last;
    logic          pq_valid;
    logic          pq_write;
    logic [DL-1:0] pq_data;
    logic          pq_rvalid;
    logic [DL-1:0] pq_rdata;
    logic          pq_empty;
    logic          err;

    always #5 CLK = ~CLK;

    pq_stream_sorter #(
        .QUEUE_DEPTH(QD),
        .DATA_LENGTH(DL)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .pq_valid (pq_valid),
        .pq_write (pq_write),
        .pq_data  (pq_data),
        .pq_rvalid(pq_rvalid),
        .pq_rdata (pq_rdata),
        .pq_empty (pq_empty),
        .err      (err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural priority queue ----------------
    logic [DL-1:0] pq_mem[$];
    int pushes;
    int pops;

    function automatic int ins_pos(input logic [DL-1:0] v);
        for (int i = 0; i < pq_mem.size(); i++)
            if (v < pq_mem[i]) return i;
        return pq_mem.size();
    endfunction

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pq_mem.delete();
            pq_rvalid <= 1'b0;
            pq_rdata  <= '0;
            pq_empty  <= 1'b1;
            pushes    <= 0;
            pops      <= 0;
        end else begin
            pq_empty  <= (pq_mem.size() == 0);
            pq_rvalid <= 1'b0;
            if (pq_valid && pq_write) begin
                pq_mem.insert(ins_pos(pq_data), pq_data);
                pushes <= pushes + 1;
            end else if (pq_valid) begin
                pq_rvalid <= 1'b1;
                pq_rdata  <= (pq_mem.size() > 0) ? pq_mem[0] : '0;
                if (pq_mem.size() > 0) pq_mem.delete(0);
                pops <= pops + 1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [DL-1:0] d;
        logic          l;
    } exp_t;

    exp_t sb[$];
    logic rdy_stall = 1'b0;
    logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   nout = 0;

    initial begin
        int   ph = 0;
        int   cyc = 0;
        int   prev_cyc = 0;
        logic first = 1'b1;
        logic held = 1'b0;
        logic [DL-1:0] held_d = '0;
        logic held_l = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rdy_stall) begin
                m_ready = rdy_pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                m_ready = 1'b1;
                ph = 0;
            end
            if (RSTn) begin
                cyc++;
                if (held) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data", m_data, held_d);
                    chk("hold_last", m_last, held_l);
                end
                held   = m_valid && !m_ready;
                held_d = m_data;
                held_l = m_last;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        chk("extra_out", m_data, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("m_data", m_data, e.d);
                        chk("m_last", m_last, e.l);
                        if (!rdy_stall && !first) chk("tput_gap", cyc - prev_cyc, 1);
                        first    = e.l;
                        prev_cyc = cyc;
                        nout++;
                    end
                end
            end else begin
                held  = 1'b0;
                first = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_batch(input logic [DL-1:0] v[$]);
        logic [DL-1:0] s[$];
        exp_t e;
        s = v;
        s.sort();
        foreach (s[i]) begin
            e.d = s[i];
            e.l = (i == s.size() - 1);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send(input logic [DL-1:0] d, input logic l);
        int g = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (!s_ready) chk("s_ready_timeout", 0, 1);
        @(negedge CLK);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic run_batch(input logic [DL-1:0] v[$]);
        expect_batch(v);
        foreach (v[i]) send(v[i], i == v.size() - 1);
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while (sb.size() > 0 && g < 500) begin
            @(negedge CLK);
            g++;
        end
        chk({tag, "_drained"}, sb.size(), 0);
        @(negedge CLK);
        chk({tag, "_back_to_fill"}, s_ready, 1);
        chk({tag, "_push_eq_pop"}, pops, pushes);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_pq_valid"}, pq_valid, 0);
        chk({tag, "_pq_write"}, pq_write, 0);
        chk({tag, "_pq_data"}, pq_data, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DL-1:0] bq[$];
        int base;
        int g;

        repeat (3) @(negedge CLK);
        chk_reset("rst0");
        RSTn = 1'b1;
        @(negedge CLK);

        bq = '{8'd7, 8'd3, 8'd9, 8'd1};
        run_batch(bq);
        wait_drain("basic");

        // Five beats with no last: the queue fills after four, the fifth waits.
        bq = '{8'd50, 8'd20, 8'd80, 8'd10};
        expect_batch(bq);
        bq = '{8'd30, 8'd60};
        expect_batch(bq);
        send(8'd50, 1'b0);
        send(8'd20, 1'b0);
        send(8'd80, 1'b0);
        send(8'd10, 1'b0);
        chk("full_s_ready", s_ready, 0);
        send(8'd30, 1'b0);
        send(8'd60, 1'b1);
        wait_drain("full");

        rdy_stall = 1'b1;
        bq = '{8'd4, 8'd2, 8'd8, 8'd6};
        run_batch(bq);
        wait_drain("stall");
        rdy_stall = 1'b0;

        bq = '{8'd42};
        run_batch(bq);
        wait_drain("single");

        bq = '{8'd5, 8'd5, 8'd2};
        run_batch(bq);
        wait_drain("equal");

        // Back-to-back batches with no idle gap between them.
        bq = '{8'd200, 8'd100, 8'd150, 8'd120};
        run_batch(bq);
        bq = '{8'd11, 8'd33, 8'd22};
        run_batch(bq);
        wait_drain("b2b");

        base = nout;
        bq = '{8'd10, 8'd40, 8'd20, 8'd30};
        run_batch(bq);
        g = 0;
        while (nout < base + 2 && g < 200) begin
            @(negedge CLK);
            g++;
        end
        chk("mid_two_out", (nout >= base + 2), 1);
        @(posedge CLK);
        #1 RSTn = 1'b0;
        #1 chk_reset("rst_mid");
        sb.delete();
        repeat (2) @(negedge CLK);
        chk_reset("rst_hold");
        RSTn = 1'b1;
        @(negedge CLK);
        bq = '{8'd8, 8'd6};
        run_batch(bq);
        wait_drain("after_rst");

        chk("err_final", err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
